// File: rtl/cpu_run_monitor_if.sv
// Bus between the CPU run monitor and its environment: CPU fetch taps,
// run-control outputs and the post-mortem trace read port.
interface cpu_run_monitor_if #(
   parameter int PC_W        = 32,
   parameter int INSTR_W     = 32,
   parameter int CNT_W       = 16,
   parameter int TRACE_DEPTH = 8
);
   localparam int AW = $clog2(TRACE_DEPTH);

   logic               restart;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               cpu_reset;
   logic               running;
   logic               done;
   logic [2:0]         halt_cause;
   logic [CNT_W-1:0]   cycle_count;
   logic [AW:0]        trace_count;
   logic [AW-1:0]      trace_rd_idx;
   logic [PC_W-1:0]    trace_rd_pc;

   modport master (
      output restart, pc, instr, instr_valid, trace_rd_idx,
      input  cpu_reset, running, done, halt_cause, cycle_count, trace_count, trace_rd_pc
   );

   modport slave (
      input  restart, pc, instr, instr_valid, trace_rd_idx,
      output cpu_reset, running, done, halt_cause, cycle_count, trace_count, trace_rd_pc
   );
endinterface

// File: rtl/cpu_run_monitor.sv
// Run-control monitor for a single-cycle CPU: sequences CPU reset, counts run
// cycles, detects termination and keeps a circular trace of fetched PCs.
module cpu_run_monitor #(
   parameter int                 PC_W             = 32,
   parameter int                 INSTR_W          = 32,
   parameter logic [INSTR_W-1:0] HALT_INSTR       = 'h0000000C,
   parameter int                 RESET_CYCLES     = 4,
   parameter int                 SELF_LOOP_CYCLES = 3,
   parameter int                 MAX_CYCLES       = 1000,
   parameter int                 CNT_W            = 16,
   parameter int                 TRACE_DEPTH      = 8
) (
   input  logic               clk,
   input  logic               reset,
   cpu_run_monitor_if.slave   bus
);
   localparam int AW = $clog2(TRACE_DEPTH);
   localparam int TW = AW + 1;
   localparam int HW = $clog2(RESET_CYCLES) + 1;
   localparam int LW = $clog2(SELF_LOOP_CYCLES) + 1;

   typedef enum logic [1:0] {S_HOLD, S_RUN, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [HW-1:0]    hold_cnt;
   logic [LW-1:0]    loop_cnt;
   logic             have_prev;
   logic [PC_W-1:0]  prev_pc;
   logic [CNT_W-1:0] cycle_count, cyc_inc;
   logic [2:0]       halt_cause, cause_nxt;
   logic [TW-1:0]    trace_count;
   logic [AW-1:0]    wp, rd_addr;
   logic [PC_W-1:0]  trace_mem [TRACE_DEPTH];
   logic             pc_same, self_hit;
   logic             cpu_reset, running, done;

   assign cyc_inc  = cycle_count + CNT_W'(1);
   assign pc_same  = have_prev && (bus.pc == prev_pc);
   // loop_cnt holds equal compares already seen; this one makes the N-th
   assign self_hit = pc_same && (loop_cnt == LW'(SELF_LOOP_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_HOLD;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cause_nxt = 3'd0;
      cpu_reset = 1'b1;
      running   = 1'b0;
      done      = 1'b0;
      case (state)
         S_HOLD: begin
            if (hold_cnt == HW'(RESET_CYCLES - 1)) state_nxt = S_RUN;
         end
         S_RUN: begin
            cpu_reset = 1'b0;
            running   = 1'b1;
            if (!bus.instr_valid)                         cause_nxt = 3'd3;
            else if (bus.instr == HALT_INSTR)             cause_nxt = 3'd1;
            else if (self_hit)                            cause_nxt = 3'd2;
            else if (cyc_inc == CNT_W'(MAX_CYCLES))       cause_nxt = 3'd4;
            if (cause_nxt != 3'd0) state_nxt = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (bus.restart) state_nxt = S_HOLD;
         end
         default: state_nxt = S_HOLD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_cnt    <= '0;
         loop_cnt    <= '0;
         have_prev   <= 1'b0;
         prev_pc     <= '0;
         cycle_count <= '0;
         halt_cause  <= 3'd0;
         trace_count <= '0;
         wp          <= '0;
      end else begin
         case (state)
            S_HOLD: begin
               hold_cnt <= (state_nxt == S_RUN) ? '0 : hold_cnt + HW'(1);
            end
            S_RUN: begin
               cycle_count <= cyc_inc;
               halt_cause  <= cause_nxt;
               prev_pc     <= bus.pc;
               have_prev   <= 1'b1;
               loop_cnt    <= pc_same ? loop_cnt + LW'(1) : '0;
               wp          <= wp + AW'(1);
               if (trace_count != TW'(TRACE_DEPTH)) trace_count <= trace_count + TW'(1);
            end
            S_DONE: begin
               if (bus.restart) begin
                  cycle_count <= '0;
                  halt_cause  <= 3'd0;
                  trace_count <= '0;
                  loop_cnt    <= '0;
                  have_prev   <= 1'b0;
                  hold_cnt    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // trace storage needs no reset: trace_count gates every read
   always_ff @(posedge clk) begin
      if (state == S_RUN) trace_mem[wp] <= bus.pc;
   end

   assign rd_addr          = wp - AW'(1) - bus.trace_rd_idx;
   assign bus.trace_rd_pc  = ({1'b0, bus.trace_rd_idx} >= trace_count) ? '0 : trace_mem[rd_addr];
   assign bus.cpu_reset    = cpu_reset;
   assign bus.running      = running;
   assign bus.done         = done;
   assign bus.halt_cause   = halt_cause;
   assign bus.cycle_count  = cycle_count;
   assign bus.trace_count  = trace_count;
endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
Parametrised run-control and termination monitor placed beside the single-cycle CPU. It replaces ad-hoc bench-side reset pulsing, fixed-delay finishing and X-instruction detection.
- Sequences CPU reset.
- Counts run cycles.
- Detects program termination (halt instruction, jump-to-self, invalid fetch, timeout).
- Keeps a circular trace of the last fetched PCs for post-mortem readout.
It is synthesizable and reusable by any CPU variant via width parameters.

Parameters:
PC_W, 32, program counter width
INSTR_W, 32, instruction width
HALT_INSTR, 32'h0000000C, encoding treated as halt (MIPS syscall)
RESET_CYCLES, 4, cycles cpu_reset held high after leaving reset or on restart (>=1)
SELF_LOOP_CYCLES, 3, consecutive unchanged-PC cycles that declare jump-to-self (>=1)
MAX_CYCLES, 1000, run-cycle timeout
CNT_W, 16, cycle counter width (must hold MAX_CYCLES)
TRACE_DEPTH, 8, trace buffer entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
restart  in  1  single-cycle pulse; honoured only in DONE
pc  in  PC_W  CPU fetch PC, sampled every cycle
instr  in  INSTR_W  CPU fetched instruction
instr_valid  in  1  fetched word is defined/in-range; low = invalid fetch
cpu_reset  out  1  reset to CPU
running  out  1  high in RUN
done  out  1  high in DONE
halt_cause  out  3  0 none, 1 halt instr, 2 self-loop, 3 invalid fetch, 4 timeout
cycle_count  out  CNT_W  RUN cycles elapsed
trace_count  out  $clog2(TRACE_DEPTH)+1  valid trace entries, saturating
trace_rd_idx  in  $clog2(TRACE_DEPTH)  0 = most recent entry
trace_rd_pc  out  PC_W  combinational read of entry trace_rd_idx

Behaviour:
- Clock is clk; reset is asynchronous, active-high, named reset. Asserting reset mid-operation aborts immediately.
- Values while reset is asserted: state HOLD, cpu_reset=1, running=0, done=0, halt_cause=0, cycle_count=0, trace_count=0, hold counter=0, loop counter=0.
- HOLD:
  - cpu_reset=1; counts RESET_CYCLES clock edges after reset deasserts.
  - On the last edge, moves to RUN; cpu_reset drops with the state change.
- RUN, each rising edge:
  - Sample pc/instr/instr_valid.
  - Increment cycle_count.
  - Push pc into the trace.
  - Evaluate terminations using the sampled values.
- Termination checks, priority when several are true in the same cycle: invalid fetch (3) > halt instr (2... code 1) > self-loop (2) > timeout (4). Precisely:
  - instr_valid=0 -> cause 3.
  - instr==HALT_INSTR -> cause 1.
  - pc equal to the previous sampled pc for SELF_LOOP_CYCLES consecutive compares -> cause 2. The loop counter resets on any pc change. The first RUN cycle has no previous pc and does not compare.
  - cycle_count post-increment == MAX_CYCLES -> cause 4.
- On termination, next state is DONE. halt_cause is registered on the same edge. The terminating cycle is counted and traced.
- DONE:
  - done=1, running=0, cpu_reset=1 (CPU frozen).
  - cycle_count, halt_cause and trace are held; pc/instr are ignored.
  - restart=1 -> HOLD. Clears cycle_count, halt_cause, trace_count and loop counter; trace contents need not clear. restart outside DONE is ignored.
- Trace:
  - Circular buffer with write pointer wrapping modulo TRACE_DEPTH.
  - trace_count increments to TRACE_DEPTH and then saturates.
  - trace_rd_pc = entry (wp-1-trace_rd_idx) mod TRACE_DEPTH.
  - If trace_rd_idx >= trace_count, output is 0.
- cycle_count never wraps; timeout fires before overflow by parameter rule.

Test Plan:
- Reset, defaults: reset high for 2 cycles, release -> cpu_reset=1 for exactly 4 edges, then running=1; cycle_count counts 1,2,3.
- Halt instruction: pc=0,4,8 with instr=0x0000000C at pc=8 -> done on that edge, halt_cause=1, cycle_count=3, trace idx0=8, idx1=4, idx2=0, trace_count=3.
- Self-loop vs timeout: pc=0x10,0x14,0x14,0x14,0x14 -> done after the third equal compare, halt_cause=2, cycle_count=5. Separately, MAX_CYCLES=20 with incrementing pc -> halt_cause=4, cycle_count=20.
- Priority and invalid fetch: instr_valid=0 together with instr=0x0000000C in the same cycle -> halt_cause=3.
- Trace wrap: 12 RUN cycles, pc=4*n (n=0..11), then timeout at MAX_CYCLES=12 -> trace_count=8, idx0=0x2C, idx7=0x10.
- Restart and reset mid-run: restart in DONE -> HOLD 4 cycles, counters 0, cause 0. Restart pulsed during RUN is ignored. Async reset asserted mid-cycle in RUN -> cpu_reset=1 and running=0 without waiting for a clock edge.
